rr_burst_arbiter: RTL and testbench
===================================

// Module: rr_burst_arbiter
// PURPOSE
//  Work-conserving N:1 round-robin arbiter for shared switch resources (packet memory, free list).
//  Idle ports are skipped, so no TDM slot is wasted. Multi-beat bursts keep the grant locked until the last beat.
//  An in-order tag FIFO steers each returned response (e.g. memory rvalid/rdata) back to the requesting port.
// PARAMETERS
//  N          switch_pkg::NUM_PORTS  number of requesting ports (>=2)
//  DATA_W     mem_pkg::BLOCK_BITS    request/response payload width
//  ADDR_W     mem_pkg::ADDR_W        request address width
//  RSP_DEPTH  4                      outstanding-response tag FIFO depth (power of 2)
//  MAX_BURST  8                      beat cap per lock (used only with ARB_BURST_CAP_EN)
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  async active-low reset
//  req_i        in   [N] x 1            port requests a beat
//  addr_i       in   [N] x ADDR_W       per-port address
//  data_i       in   [N] x DATA_W       per-port write payload
//  last_i       in   [N] x 1            beat is the last of its burst
//  rsp_exp_i    in   [N] x 1            beat expects one response
//  gnt_o        out  [N] x 1            beat accepted this cycle (one-hot or zero)
//  out_valid_o  out  1                  downstream beat valid
//  out_ready_i  in   1                  downstream accepts
//  out_addr_o   out  ADDR_W             selected address
//  out_data_o   out  DATA_W             selected payload
//  out_last_o   out  1                  selected last_i
//  out_port_o   out  $clog2(N)          selected port index
//  resp_valid_i in   1                  downstream response beat
//  resp_data_i  in   DATA_W             response payload
//  resp_valid_o out  [N] x 1            response steered to FIFO-head port
//  resp_data_o  out  DATA_W             response payload broadcast to all ports
//  err_o        out  1                  sticky: response arrived with tag FIFO empty
// BEHAVIOUR
//  - State IDLE / LOCKED, plus ptr (port index) and lock_port. Reset: IDLE, ptr=0, FIFO empty, err_o=0.
//  - While rst_n is low: all outputs 0.
//  - Eligible(p) = req_i[p] & ~(rsp_exp_i[p] & fifo_full). A full FIFO blocks even on a same-cycle pop,
//    so there is no combinational path from resp_valid_i to grant.
//  - IDLE: sel = first eligible port scanning ptr, ptr+1 .. ptr+N-1 (mod N). out_valid_o = any eligible.
//  - LOCKED: sel = lock_port only. out_valid_o = Eligible(lock_port).
//    A dropped request holds the lock; no other port is served.
//  - Output path is combinational (0-cycle latency). xfer = out_valid_o & out_ready_i; gnt_o[sel] = xfer.
//  - On xfer with last=1: state IDLE, ptr <= sel+1 (wraps N-1 -> 0).
//  - On xfer with last=0: state LOCKED, lock_port <= sel, ptr is unchanged.
//  - out_valid_o does not depend on out_ready_i. Payload is held stable while valid & ~ready.
//  - Tag FIFO push on xfer & rsp_exp_i[sel] (tag = sel).
//    Pop on resp_valid_i: resp_valid_o[head]=1, same cycle.
//  - Push and pop in the same cycle leave the count unchanged. The FIFO is never pushed when full.
//  - resp_valid_i with FIFO empty: no resp_valid_o, err_o <= 1 until reset.
//  - Reset mid-burst: lock dropped, outstanding tags discarded.
// CONFIGURATION
//  - ARB_BURST_CAP_EN defined: a beat counter counts xfers within a lock.
//    On the MAX_BURST-th xfer without last: lock released, state IDLE, ptr <= lock_port+1.
//    The port's remaining beats rearbitrate as a new lock.
//  - ARB_BURST_CAP_EN undefined: lock length unbounded, no counter, MAX_BURST ignored.
// STRUCTURE
//  - arb_pkg: typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e; typedef port index type;
//    function rr_pick(req vector, ptr) -> index + found flag.
//  - Sub-module rsp_tag_fifo: sync FIFO of $clog2(N)-bit tags, depth RSP_DEPTH, full/empty, async reset.
//  - Parent holds the FSM, ptr, optional beat counter and muxes.
// TESTING
//  - N=4, reset, all req_i=1 single-beat (last=1), ready=1 -> gnt order 0,1,2,3,0 on consecutive cycles.
//  - Only ports 1,3 request -> gnt 1,3,1,3 with no idle cycles (work-conserving).
//  - Port 2 burst of 3 beats with port 0 requesting; ready low on beat 2 for 2 cycles
//    -> gnt 2,2,2 with payload stable during stall, then port 0.
//  - RSP_DEPTH=4: 5 rsp_exp reads from port 1, no responses -> 4 grants then stall.
//    One resp_valid_i -> resp_valid_o[1]=1, 5th read granted the next cycle.
//  - resp_valid_i with FIFO empty -> resp_valid_o all 0, err_o=1 and held; rst_n low mid-burst -> all outputs 0, ptr=0.
//  - ARB_BURST_CAP_EN, MAX_BURST=8: port 0 10-beat burst, port 1 requesting
//    -> 8 beats from port 0, then port 1, then port 0's last 2 beats.

Source files
------------

// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and the round-robin pick helper for rr_burst_arbiter.
package arb_pkg;

  localparam int ARB_NUM_PORTS = 4;
  localparam int ARB_DATA_W    = 32;
  localparam int ARB_ADDR_W    = 16;
  localparam int PICK_MAX      = 16;
  localparam int PICK_IDX_W    = 4;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
  typedef logic [$clog2(ARB_NUM_PORTS)-1:0] port_idx_t;

  typedef struct packed {
    logic                  found;
    logic [PICK_IDX_W-1:0] idx;
  } pick_t;

  // First set bit of req scanning ptr, ptr+1 .. ptr+n-1 (mod n); ptr must be < n.
  function automatic pick_t rr_pick(input logic [PICK_MAX-1:0] req,
                                    input logic [PICK_IDX_W-1:0] ptr,
                                    input int n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = PICK_MAX-1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (req[PICK_IDX_W'(j)]) begin
          r.found = 1'b1;
          r.idx   = PICK_IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter_if.sv
// Request, downstream and response bundle for rr_burst_arbiter.
interface rr_burst_arbiter_if #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) ();
  logic [N-1:0]                     req_i;
  logic [N-1:0][ADDR_W-1:0]         addr_i;
  logic [N-1:0][DATA_W-1:0]         data_i;
  logic [N-1:0]                     last_i;
  logic [N-1:0]                     rsp_exp_i;
  logic [N-1:0]                     gnt_o;
  logic                             out_valid_o;
  logic                             out_ready_i;
  logic [ADDR_W-1:0]                out_addr_o;
  logic [DATA_W-1:0]                out_data_o;
  logic                             out_last_o;
  logic [$clog2(N)-1:0]             out_port_o;
  logic                             resp_valid_i;
  logic [DATA_W-1:0]                resp_data_i;
  logic [N-1:0]                     resp_valid_o;
  logic [DATA_W-1:0]                resp_data_o;
  logic                             err_o;

  // Requesters plus downstream memory side.
  modport master (
    output req_i, addr_i, data_i, last_i, rsp_exp_i, out_ready_i, resp_valid_i, resp_data_i,
    input  gnt_o, out_valid_o, out_addr_o, out_data_o, out_last_o, out_port_o,
           resp_valid_o, resp_data_o, err_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, addr_i, data_i, last_i, rsp_exp_i, out_ready_i, resp_valid_i, resp_data_i,
    output gnt_o, out_valid_o, out_addr_o, out_data_o, out_last_o, out_port_o,
           resp_valid_o, resp_data_o, err_o
  );
endinterface

// File: rtl/rr_burst_arbiter_rsp_tag_fifo.sv
// In-order FIFO of port tags for outstanding responses.
module rsp_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr, rd;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr  <= '0;
      rd  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr] <= push_tag;
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// Work-conserving round-robin N:1 arbiter with burst lock and in-order response steering.
// Optional ARB_BURST_CAP_EN: release the lock after MAX_BURST beats without last.
module rr_burst_arbiter import arb_pkg::*; #(
  parameter int N         = ARB_NUM_PORTS,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int RSP_DEPTH = 4,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst_n,
  rr_burst_arbiter_if.slave bus
);
  localparam int PW = $clog2(N);

  if (N < 2 || N > PICK_MAX || RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH-1)) != 0 || MAX_BURST < 1)
  begin : g_param_chk
    $error("rr_burst_arbiter: unsupported parameter set");
  end

  arb_state_e     state;
  logic [PW-1:0]  ptr, lock_port, sel, sel_next, head;
  logic [N-1:0]   elig;
  logic           valid, xfer, push, pop, fifo_full, fifo_empty, err;
  pick_t          pick;

  always_comb begin
    // A full FIFO blocks response-expecting beats even if a pop lands this cycle.
    elig = bus.req_i & ~(bus.rsp_exp_i & {N{fifo_full}});
    pick = rr_pick(PICK_MAX'(elig), PICK_IDX_W'(ptr), N);
    if (state == ARB_LOCKED) begin
      sel   = lock_port;
      valid = elig[lock_port];
    end else begin
      sel   = PW'(pick.idx);
      valid = pick.found;
    end
  end

  assign xfer     = valid & bus.out_ready_i;
  assign sel_next = (sel == PW'(N-1)) ? '0 : sel + 1'b1;
  assign push     = xfer & bus.rsp_exp_i[sel];
  assign pop      = bus.resp_valid_i & ~fifo_empty;

`ifdef ARB_BURST_CAP_EN
  localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CW-1:0] beat_cnt;
  logic          cap_hit;

  assign cap_hit = (beat_cnt == CW'(MAX_BURST-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    beat_cnt <= '0;
    else if (xfer) beat_cnt <= (bus.last_i[sel] || cap_hit) ? '0 : beat_cnt + 1'b1;
  end
`else
  logic cap_hit;
  assign cap_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      lock_port <= '0;
    end else if (xfer) begin
      if (bus.last_i[sel] || cap_hit) begin
        state <= ARB_IDLE;
        ptr   <= sel_next;
      end else begin
        state     <= ARB_LOCKED;
        lock_port <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           err <= 1'b0;
    else if (bus.resp_valid_i && fifo_empty) err <= 1'b1;
  end

  rsp_tag_fifo #(.TAG_W(PW), .DEPTH(RSP_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_tag (sel),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Everything is forced low while reset is held.
  assign bus.gnt_o        = (rst_n && xfer) ? (N'(1) << sel) : '0;
  assign bus.out_valid_o  = rst_n & valid;
  assign bus.out_addr_o   = rst_n ? bus.addr_i[sel] : '0;
  assign bus.out_data_o   = rst_n ? bus.data_i[sel] : '0;
  assign bus.out_last_o   = rst_n & bus.last_i[sel];
  assign bus.out_port_o   = rst_n ? sel : '0;
  assign bus.resp_valid_o = (rst_n && pop) ? (N'(1) << head) : '0;
  assign bus.resp_data_o  = rst_n ? bus.resp_data_i : '0;
  assign bus.err_o        = rst_n & err;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed scoreboard bench for rr_burst_arbiter (N=4, RSP_DEPTH=4, MAX_BURST=8).
module tb_rr_burst_arbiter;
  localparam int N = 4, DW = 32, AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  rr_burst_arbiter_if #(.N(N), .DATA_W(DW), .ADDR_W(AW)) bus ();
  rr_burst_arbiter #(.N(N), .DATA_W(DW), .ADDR_W(AW), .RSP_DEPTH(4), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {int cyc; int port; logic [AW-1:0] addr; logic [DW-1:0] data; logic last;} gexp_t;
  typedef struct {int cyc; int port; logic [DW-1:0] data;} rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];

  function automatic logic [AW-1:0] A(input int p, input int b);
    return AW'(32'h1000 + p*256 + b);
  endfunction
  function automatic logic [DW-1:0] D(input int p, input int b);
    return 32'hD000_0000 | DW'(p << 8) | DW'(b);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic r, input int b, input logic l, input logic x);
    bus.req_i[p]     = r;
    bus.addr_i[p]    = A(p, b);
    bus.data_i[p]    = D(p, b);
    bus.last_i[p]    = l;
    bus.rsp_exp_i[p] = x;
  endtask

  task automatic idle_all();
    bus.req_i        = '0;
    bus.last_i       = '0;
    bus.rsp_exp_i    = '0;
    bus.out_ready_i  = 1'b1;
    bus.resp_valid_i = 1'b0;
  endtask

  task automatic resp(input logic [DW-1:0] d);
    bus.resp_valid_i = 1'b1;
    bus.resp_data_i  = d;
  endtask

  task automatic exp_g(input int p, input int b, input logic l);
    gq.push_back('{cyc, p, A(p, b), D(p, b), l});
  endtask
  task automatic exp_r(input int p, input logic [DW-1:0] d);
    rq.push_back('{cyc, p, d});
  endtask

  // Monitor: pops an expectation whenever the DUT grants or steers a response.
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    if (bus.gnt_o != '0) begin
      if (gq.size() == 0) chk("gnt_unexpected", 64'(bus.gnt_o), 64'(0));
      else begin
        g = gq.pop_front();
        chk("gnt_cycle", 64'(cyc), 64'(g.cyc));
        chk("gnt", 64'(bus.gnt_o), 64'(1) << g.port);
        chk("out_valid", 64'(bus.out_valid_o), 64'(1));
        chk("out_port", 64'(bus.out_port_o), 64'(g.port));
        chk("out_addr", 64'(bus.out_addr_o), 64'(g.addr));
        chk("out_data", 64'(bus.out_data_o), 64'(g.data));
        chk("out_last", 64'(bus.out_last_o), 64'(g.last));
      end
    end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
      g = gq.pop_front();
      chk("gnt_missing", 64'(bus.gnt_o), 64'(1) << g.port);
    end
    if (bus.resp_valid_o != '0) begin
      if (rq.size() == 0) chk("resp_unexpected", 64'(bus.resp_valid_o), 64'(0));
      else begin
        r = rq.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(r.cyc));
        chk("resp_valid", 64'(bus.resp_valid_o), 64'(1) << r.port);
        chk("resp_data", 64'(bus.resp_data_o), 64'(r.data));
      end
    end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
      r = rq.pop_front();
      chk("resp_missing", 64'(bus.resp_valid_o), 64'(1) << r.port);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.addr_i = '0; bus.data_i = '0; bus.resp_data_i = '0;
    idle_all();
    tick();

    // Reset with busy inputs: every output must be low.
    for (int p = 0; p < N; p++) drv(p, 1'b1, 7, 1'b1, 1'b1);
    resp(32'h5555_AAAA);
    @(negedge clk);
    chk("rst_gnt", 64'(bus.gnt_o), 64'(0));
    chk("rst_valid", 64'(bus.out_valid_o), 64'(0));
    chk("rst_addr", 64'(bus.out_addr_o), 64'(0));
    chk("rst_data", 64'(bus.out_data_o), 64'(0));
    chk("rst_last", 64'(bus.out_last_o), 64'(0));
    chk("rst_port", 64'(bus.out_port_o), 64'(0));
    chk("rst_rvalid", 64'(bus.resp_valid_o), 64'(0));
    chk("rst_rdata", 64'(bus.resp_data_o), 64'(0));
    chk("rst_err", 64'(bus.err_o), 64'(0));
    tick();
    idle_all();
    rst_n = 1'b1;
    tick();

    // All ports single-beat: 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < N; p++) drv(p, 1'b1, i, 1'b1, 1'b0);
      exp_g(i % 4, i, 1'b1);
      tick();
    end

    // Ports 1 and 3 only: no idle cycles.
    idle_all();
    for (int i = 0; i < 4; i++) begin
      drv(1, 1'b1, 10+i, 1'b1, 1'b0);
      drv(3, 1'b1, 10+i, 1'b1, 1'b0);
      exp_g((i % 2) ? 3 : 1, 10+i, 1'b1);
      tick();
    end

    // Port 2 three-beat burst with a two-cycle stall on beat 2, port 0 waiting.
    idle_all();
    drv(2, 1'b1, 0, 1'b0, 1'b0);
    exp_g(2, 0, 1'b0);
    tick();
    drv(0, 1'b1, 0, 1'b1, 1'b0);
    drv(2, 1'b1, 1, 1'b0, 1'b0);
    bus.out_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid_o), 64'(1));
      chk("stall_port", 64'(bus.out_port_o), 64'(2));
      chk("stall_addr", 64'(bus.out_addr_o), 64'(A(2, 1)));
      chk("stall_data", 64'(bus.out_data_o), 64'(D(2, 1)));
      tick();
    end
    bus.out_ready_i = 1'b1;
    exp_g(2, 1, 1'b0);
    tick();
    drv(2, 1'b1, 2, 1'b1, 1'b0);
    exp_g(2, 2, 1'b1);
    tick();
    drv(2, 1'b0, 2, 1'b1, 1'b0);
    exp_g(0, 0, 1'b1);
    tick();

    // Tag FIFO fills after four reads; a response frees one slot a cycle later.
    idle_all();
    for (int i = 0; i < 4; i++) begin
      drv(1, 1'b1, i, 1'b1, 1'b1);
      exp_g(1, i, 1'b1);
      tick();
    end
    drv(1, 1'b1, 4, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_block", 64'(bus.out_valid_o), 64'(0));
    tick();
    resp(32'hA000_0000);
    exp_r(1, 32'hA000_0000);
    @(negedge clk);
    chk("full_same_pop", 64'(bus.out_valid_o), 64'(0));
    tick();
    bus.resp_valid_i = 1'b0;
    exp_g(1, 4, 1'b1);
    tick();

    // Drain in order while port 3 pushes during a pop.
    idle_all();
    drv(3, 1'b1, 0, 1'b1, 1'b1);
    resp(32'hA000_0001);
    exp_r(1, 32'hA000_0001);
    @(negedge clk);
    chk("full_block3", 64'(bus.out_valid_o), 64'(0));
    tick();
    resp(32'hA000_0002);
    exp_r(1, 32'hA000_0002);
    exp_g(3, 0, 1'b1);
    tick();
    drv(3, 1'b0, 0, 1'b1, 1'b0);
    resp(32'hA000_0003);
    exp_r(1, 32'hA000_0003);
    tick();
    resp(32'hA000_0004);
    exp_r(1, 32'hA000_0004);
    tick();
    resp(32'hA000_0005);
    exp_r(3, 32'hA000_0005);
    tick();
    resp(32'hA000_0006);
    @(negedge clk);
    chk("empty_rvalid", 64'(bus.resp_valid_o), 64'(0));
    chk("err_pre", 64'(bus.err_o), 64'(0));
    tick();
    bus.resp_valid_i = 1'b0;
    @(negedge clk);
    chk("err_set", 64'(bus.err_o), 64'(1));
    tick();
    @(negedge clk);
    chk("err_held", 64'(bus.err_o), 64'(1));
    tick();

    // Reset in the middle of a locked burst with a tag outstanding.
    drv(1, 1'b1, 0, 1'b0, 1'b1);
    exp_g(1, 0, 1'b0);
    tick();
    drv(1, 1'b1, 1, 1'b1, 1'b0);
    drv(0, 1'b1, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", 64'(bus.gnt_o), 64'(0));
    chk("mid_rst_valid", 64'(bus.out_valid_o), 64'(0));
    chk("mid_rst_addr", 64'(bus.out_addr_o), 64'(0));
    chk("mid_rst_err", 64'(bus.err_o), 64'(0));
    tick();
    rst_n = 1'b1;
    exp_g(0, 0, 1'b1);
    tick();
    drv(0, 1'b0, 0, 1'b1, 1'b0);
    exp_g(1, 1, 1'b1);
    tick();
    idle_all();
    resp(32'hB000_0000);
    @(negedge clk);
    chk("post_rst_rvalid", 64'(bus.resp_valid_o), 64'(0));
    chk("post_rst_err0", 64'(bus.err_o), 64'(0));
    tick();
    bus.resp_valid_i = 1'b0;
    @(negedge clk);
    chk("post_rst_err1", 64'(bus.err_o), 64'(1));
    tick();

    // Port 0 ten-beat burst with port 1 requesting.
    idle_all();
    drv(0, 1'b1, 0, 1'b0, 1'b0);
    exp_g(0, 0, 1'b0);
    tick();
`ifdef ARB_BURST_CAP_EN
    for (int b = 1; b < 8; b++) begin
      drv(0, 1'b1, b, 1'b0, 1'b0);
      drv(1, 1'b1, 0, 1'b1, 1'b0);
      exp_g(0, b, 1'b0);
      tick();
    end
    drv(0, 1'b1, 8, 1'b0, 1'b0);
    exp_g(1, 0, 1'b1);
    tick();
    drv(1, 1'b0, 0, 1'b1, 1'b0);
    exp_g(0, 8, 1'b0);
    tick();
    drv(0, 1'b1, 9, 1'b1, 1'b0);
    exp_g(0, 9, 1'b1);
    tick();
`else
    for (int b = 1; b < 10; b++) begin
      drv(0, 1'b1, b, (b == 9), 1'b0);
      drv(1, 1'b1, 0, 1'b1, 1'b0);
      exp_g(0, b, (b == 9));
      tick();
    end
    drv(0, 1'b0, 9, 1'b1, 1'b0);
    exp_g(1, 0, 1'b1);
    tick();
`endif
    idle_all();
    tick();
    tick();
    chk("gq_drained", 64'(gq.size()), 64'(0));
    chk("rq_drained", 64'(rq.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
